// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that lets NUM_REQ requesters share one UART TX line.
// Each frame is a start bit, DATA_WIDTH bits LSB first and a stop bit, paced by i_Tx_ClkTick rising edges.

module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_Tx_ClkTick,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [$clog2(NUM_REQ)-1:0]    o_active_id,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_tx_serial
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic                  tick_q, tick_d, tick_rise;
  logic                  line_q, line_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ID_W-1:0]       active_id_q, active_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [ID_W-1:0]       cand;

  assign tick_d    = i_Tx_ClkTick;
  assign tick_rise = i_Tx_ClkTick & ~tick_q;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign req_data[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk the requesters once, starting just after the last winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to hold (or to 0 for pulses) so no path infers a latch.
    state_d     = state_q;
    line_d      = line_q;
    grant_d     = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    active_id_d = active_id_q;
    rr_ptr_d    = rr_ptr_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (pick_found) begin
          grant_d[pick_idx] = 1'b1;
          data_d            = req_data[pick_idx];
          active_id_d       = pick_idx;
          rr_ptr_d          = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          busy_d            = 1'b1;
          state_d           = WAIT;
        end
      end
      WAIT: begin
        // A rising tick seen while the grant pulse is still out is too early to start a bit.
        if (tick_rise && !grant_q) begin
          line_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick_rise) begin
          line_d    = data_q[0];
          data_d    = data_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            line_d  = 1'b1;
            state_d = STOP;
          end else begin
            line_d    = data_q[0];
            data_d    = data_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_rise) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        line_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      line_q      <= 1'b1;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      active_id_q <= '0;
      rr_ptr_q    <= '0;
      // NOTE: the payload register is a plain flop bank, so it is reset along with the control state.
      data_q      <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      line_q      <= line_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      active_id_q <= active_id_d;
      rr_ptr_q    <= rr_ptr_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_active_id = active_id_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_tx_serial = line_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed corner cases plus randomized request traffic,
// checked against a round-robin / frame-bit model derived from the protocol rules.

module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int M_DROP  = 0;
  localparam int M_KEEP  = 1;
  localparam int M_SET   = 2;
  localparam int M_RAND  = 3;

  logic                 clk;
  logic                 reset_n;
  logic                 tick;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*DW-1:0] i_data;
  logic [NUM_REQ-1:0]   o_grant;
  logic [1:0]           o_active_id;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_tx_serial;

  logic [DW-1:0] bytes [NUM_REQ];
  logic          tick_run;
  logic          tick_man;
  int            tick_half;
  int            tick_cnt;
  logic          prev_tick;
  logic          rise;
  int            model_ptr;
  int            n_checks;
  int            n_pass;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_Tx_ClkTick(tick),
    .i_req       (req),
    .i_data      (i_data),
    .o_grant     (o_grant),
    .o_active_id (o_active_id),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_tx_serial (o_tx_serial)
  );

  assign i_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-time generator: free-running square wave, or held at tick_man when stopped.
  initial begin
    tick     = 1'b0;
    tick_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!tick_run) begin
        tick     = tick_man;
        tick_cnt = 0;
      end else if (tick_cnt >= tick_half - 1) begin
        tick     = ~tick;
        tick_cnt = 0;
      end else begin
        tick_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rr_expect(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (r[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    rise      = tick & ~prev_tick;
    prev_tick = tick;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (rise) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) check("done_single_pulse", {31'd0, o_done}, 0);
      if (o_grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 0, 1);
  endtask

  task automatic expect_grant(input int id);
    check("grant_onehot", {28'd0, o_grant}, 32'd1 << id);
    check("active_id", {30'd0, o_active_id}, id);
    check("busy_at_grant", {31'd0, o_busy}, 1);
    model_ptr = (id + 1) % NUM_REQ;
  endtask

  // Expects start, data LSB first, stop; each bit appears the cycle after a tick rise and holds to the next.
  task automatic frame_check(input logic [DW-1:0] b);
    logic [9:0] bits;
    logic       held;
    bit         ok;
    bits = {1'b1, b, 1'b0};
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_rise(ok);
      if (!ok) return;
      check("bit_hold", {31'd0, o_tx_serial}, {31'd0, held});
      step();
      check("bit_value", {31'd0, o_tx_serial}, {31'd0, bits[i]});
      check("busy_in_frame", {31'd0, o_busy}, 1);
      if (i == 0) check("grant_single_pulse", {28'd0, o_grant}, 0);
      held = bits[i];
    end
    wait_rise(ok);
    if (!ok) return;
    check("stop_hold", {31'd0, o_tx_serial}, 1);
    check("done_not_early", {31'd0, o_done}, 0);
    step();
    check("done", {31'd0, o_done}, 1);
    check("busy_clear", {31'd0, o_busy}, 0);
    check("line_idle", {31'd0, o_tx_serial}, 1);
  endtask

  task automatic do_frame(input int mode, input logic [NUM_REQ-1:0] vec);
    int            exp;
    bit            ok;
    logic [DW-1:0] b;
    exp = rr_expect(req, model_ptr);
    if (exp < 0) begin
      check("no_request_pending", 0, 1);
      return;
    end
    wait_grant(ok);
    if (!ok) return;
    expect_grant(exp);
    b          = bytes[exp];
    bytes[exp] = 8'($urandom);
    case (mode)
      M_DROP: req[exp] = 1'b0;
      M_SET:  req = vec;
      M_RAND: begin
        req[exp] = 1'($urandom_range(0, 1));
        for (int k = 0; k < NUM_REQ; k++) begin
          if (k == exp) continue;
          if (!req[k] && $urandom_range(0, 2) == 0) begin
            bytes[k] = 8'($urandom);
            req[k]   = 1'b1;
          end else if (req[k] && $urandom_range(0, 5) == 0) begin
            req[k] = 1'b0;
          end
        end
        if (req == '0) req[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
      end
      default: ;
    endcase
    frame_check(b);
  endtask

  initial begin
    int            exp;
    bit            ok;
    logic [DW-1:0] b;
    n_checks  = 0;
    n_pass    = 0;
    model_ptr = 0;
    prev_tick = 1'b0;
    rise      = 1'b0;
    tick_run  = 1'b1;
    tick_man  = 1'b0;
    tick_half = 3;
    req       = '0;
    reset_n   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) bytes[k] = 8'($urandom);

    step();
    step();
    check("rst_line", {31'd0, o_tx_serial}, 1);
    check("rst_grant", {28'd0, o_grant}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_done", {31'd0, o_done}, 0);
    check("rst_active_id", {30'd0, o_active_id}, 0);
    reset_n = 1'b1;

    // Single request, byte 0xA5 from requester 2.
    bytes[2] = 8'hA5;
    req      = 4'b0100;
    do_frame(M_DROP, '0);

    // Abort mid-frame: requester 3 wins, reset hits during data bit 4.
    bytes[1] = 8'($urandom);
    bytes[3] = 8'($urandom);
    req      = 4'b1010;
    exp      = rr_expect(req, model_ptr);
    wait_grant(ok);
    if (ok) begin
      expect_grant(exp);
      for (int i = 0; i < 6; i++) begin
        wait_rise(ok);
        step();
      end
      check("mid_frame_bit4", {31'd0, o_tx_serial}, {31'd0, bytes[3][4]});
      reset_n = 1'b0;
      #1;
      check("abort_line", {31'd0, o_tx_serial}, 1);
      check("abort_busy", {31'd0, o_busy}, 0);
      check("abort_active_id", {30'd0, o_active_id}, 0);
      step();
      check("abort_no_done", {31'd0, o_done}, 0);
      reset_n   = 1'b1;
      model_ptr = 0;
    end
    do_frame(M_DROP, '0);
    do_frame(M_DROP, '0);

    // Fairness from reset with all requesters held, then skip over idle requesters.
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    model_ptr = 0;
    req       = 4'b1111;
    for (int i = 0; i < 4; i++) do_frame(M_KEEP, '0);
    do_frame(M_SET, 4'b0010);
    do_frame(M_SET, 4'b1001);
    do_frame(M_DROP, '0);
    do_frame(M_DROP, '0);

    // Tick rising in the grant cycle must not start the frame.
    tick_man = tick;
    tick_run = 1'b0;
    step();
    tick_man = 1'b0;
    step();
    step();
    step();
    bytes[0] = 8'($urandom);
    req      = 4'b0001;
    tick_man = 1'b1;
    exp      = rr_expect(req, model_ptr);
    step();
    check("grant_with_tick_rise", {28'd0, o_grant}, 32'd1 << exp);
    expect_grant(exp);
    b        = bytes[0];
    req      = '0;
    tick_run = 1'b1;
    frame_check(b);

    // Stalled tick after grant: frame waits with line high until the tick resumes.
    tick_man = tick;
    tick_run = 1'b0;
    step();
    bytes[2] = 8'($urandom);
    req      = 4'b0100;
    exp      = rr_expect(req, model_ptr);
    wait_grant(ok);
    if (ok) begin
      expect_grant(exp);
      b   = bytes[2];
      req = '0;
      for (int i = 0; i < 40; i++) step();
      check("stall_busy", {31'd0, o_busy}, 1);
      check("stall_line", {31'd0, o_tx_serial}, 1);
      check("stall_no_done", {31'd0, o_done}, 0);
      tick_run = 1'b1;
      frame_check(b);
    end

    // Randomized traffic with varying bit times.
    for (int k = 0; k < NUM_REQ; k++) bytes[k] = 8'($urandom);
    req = 4'($urandom_range(1, 15));
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) tick_half = $urandom_range(2, 5);
      do_frame(M_RAND, '0);
    end
    req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
